icebus_poll_scheduler: RTL and testbench

ICEBUS_POLL_SCHEDULER -- requirements
Module: icebus_poll_scheduler

---
 rtl/icebus_poll_scheduler_if.sv | 19 +
 rtl/icebus_poll_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_icebus_poll_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icebus_poll_scheduler_if.sv
// Handshake bundle between the poll scheduler (master) and the UART framer (slave).
interface icebus_poll_scheduler_if;
  logic       frame_req;
  logic       frame_type;
  logic [7:0] frame_motor;
  logic       frame_ack;
  logic       frame_done;
  logic       frame_ok;

  modport master (
    output frame_req, frame_type, frame_motor,
    input  frame_ack, frame_done, frame_ok
  );

  modport slave (
    input  frame_req, frame_type, frame_motor,
    output frame_ack, frame_done, frame_ok
  );
endinterface

// File: rtl/icebus_poll_scheduler.sv
// Periodic motor poll scheduler: sweeps enabled motor slots, requests setpoint/config frames.
// Optional ICEBUS_RETRY_EN: a failed frame is re-requested once before it is flagged.
module icebus_poll_scheduler #(
  parameter int unsigned NUMBER_OF_MOTORS = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 5000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 period_cycles,
  input  logic [NUMBER_OF_MOTORS-1:0] motor_enable,
  input  logic [NUMBER_OF_MOTORS-1:0] cfg_dirty_set,
  input  logic                        clear_flags,
  icebus_poll_scheduler_if.master     framer,
  output logic [NUMBER_OF_MOTORS-1:0] timeout_flags,
  output logic [NUMBER_OF_MOTORS-1:0] crc_flags,
  output logic                        overrun,
  output logic                        sweep_done
);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, WAIT} state_t;

  localparam logic [7:0]  LAST_IDX = 8'(NUMBER_OF_MOTORS);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t                      state_q, state_d;
  logic [31:0]                 tick_cnt_q, tick_cnt_d;
  logic [31:0]                 to_cnt_q, to_cnt_d;
  logic [7:0]                  idx_q, idx_d;
  logic [7:0]                  frame_motor_q, frame_motor_d;
  logic                        frame_type_q, frame_type_d;
  logic                        retry_q, retry_d;
  logic                        sweep_done_q, sweep_done_d;
  logic                        overrun_q, overrun_d;
  logic [NUMBER_OF_MOTORS-1:0] dirty_q, dirty_d;
  logic [NUMBER_OF_MOTORS-1:0] timeout_q, timeout_d;
  logic [NUMBER_OF_MOTORS-1:0] crc_q, crc_d;

  logic                        tick;
  logic [NUMBER_OF_MOTORS-1:0] idx_oh;
  logic                        en_sel, dirty_sel;
  logic                        fail_commit;
  logic [NUMBER_OF_MOTORS-1:0] dirty_clr, to_set, crc_set;

  // A shrunk period that the counter already passed restarts the count without a tick.
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q + 32'd1;
    if (period_cycles == '0) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q >= period_cycles) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == period_cycles - 32'd1) begin
      tick       = 1'b1;
      tick_cnt_d = '0;
    end
  end

  // idx == NUMBER_OF_MOTORS decodes to all-zero, so the selects below stay in range.
  always_comb begin
    idx_oh = '0;
    for (int unsigned i = 0; i < NUMBER_OF_MOTORS; i++) begin
      idx_oh[i] = (idx_q == 8'(i));
    end
  end

  assign en_sel    = |(motor_enable & idx_oh);
  assign dirty_sel = |(dirty_q & idx_oh);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    to_cnt_d      = to_cnt_q;
    frame_motor_d = frame_motor_q;
    frame_type_d  = frame_type_q;
    retry_d       = retry_q;
    sweep_done_d  = 1'b0;
    fail_commit   = 1'b0;
    dirty_clr     = '0;
    to_set        = '0;
    crc_set       = '0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          idx_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (idx_q == LAST_IDX) begin
          sweep_done_d = 1'b1;
          state_d      = IDLE;
        end else if (!en_sel) begin
          idx_d = idx_q + 8'd1;
        end else begin
          frame_motor_d = idx_q;
          frame_type_d  = dirty_sel;
          retry_d       = 1'b0;
          state_d       = REQ;
        end
      end
      REQ: begin
        if (framer.frame_ack) begin
          to_cnt_d = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (framer.frame_done && framer.frame_ok) begin
          if (frame_type_q) begin
            dirty_clr = idx_oh;
          end
          idx_d   = idx_q + 8'd1;
          state_d = SELECT;
        end else if (framer.frame_done || (to_cnt_q == TO_LAST)) begin
`ifdef ICEBUS_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = REQ;
          end else begin
            fail_commit = 1'b1;
          end
`else
          fail_commit = 1'b1;
`endif
          if (fail_commit) begin
            if (framer.frame_done) begin
              crc_set = idx_oh;
            end else begin
              to_set = idx_oh;
            end
            idx_d   = idx_q + 8'd1;
            state_d = SELECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set requests override clears in the same cycle.
  always_comb begin
    dirty_d   = (dirty_q & ~dirty_clr) | cfg_dirty_set;
    timeout_d = (clear_flags ? '0 : timeout_q) | to_set;
    crc_d     = (clear_flags ? '0 : crc_q) | crc_set;
    overrun_d = (clear_flags ? 1'b0 : overrun_q) | (tick && (state_q != IDLE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      to_cnt_q      <= '0;
      idx_q         <= '0;
      frame_motor_q <= '0;
      frame_type_q  <= 1'b0;
      retry_q       <= 1'b0;
      sweep_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      dirty_q       <= '1;
      timeout_q     <= '0;
      crc_q         <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      to_cnt_q      <= to_cnt_d;
      idx_q         <= idx_d;
      frame_motor_q <= frame_motor_d;
      frame_type_q  <= frame_type_d;
      retry_q       <= retry_d;
      sweep_done_q  <= sweep_done_d;
      overrun_q     <= overrun_d;
      dirty_q       <= dirty_d;
      timeout_q     <= timeout_d;
      crc_q         <= crc_d;
    end
  end

  assign framer.frame_req   = (state_q == REQ);
  assign framer.frame_type  = frame_type_q;
  assign framer.frame_motor = frame_motor_q;
  assign timeout_flags      = timeout_q;
  assign crc_flags          = crc_q;
  assign overrun            = overrun_q;
  assign sweep_done         = sweep_done_q;

endmodule

// File: tb/tb_icebus_poll_scheduler.sv
// Directed bench for icebus_poll_scheduler with a behavioural framer that logs every accepted frame.
module tb_icebus_poll_scheduler;
  localparam int unsigned NM = 8;
  localparam int unsigned TO = 5000;
`ifdef ICEBUS_RETRY_EN
  localparam int CRC_FRAMES = 2;
  localparam int TO_LAT     = 2 * TO + 1;
`else
  localparam int CRC_FRAMES = 1;
  localparam int TO_LAT     = TO;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   period_cycles;
  logic [NM-1:0] motor_enable;
  logic [NM-1:0] cfg_dirty_set;
  logic          clear_flags;
  logic [NM-1:0] timeout_flags;
  logic [NM-1:0] crc_flags;
  logic          overrun;
  logic          sweep_done;

  icebus_poll_scheduler_if bus ();

  icebus_poll_scheduler #(
    .NUMBER_OF_MOTORS(NM),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .period_cycles(period_cycles),
    .motor_enable (motor_enable),
    .cfg_dirty_set(cfg_dirty_set),
    .clear_flags  (clear_flags),
    .framer       (bus),
    .timeout_flags(timeout_flags),
    .crc_flags    (crc_flags),
    .overrun      (overrun),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int sd_count = 0;
  int sd_last  = 0;
  int sd_prev  = 0;
  logic [8:0] log_q[$];

  // framer behaviour knobs
  int          done_delay = 0;
  bit          done_en    = 1'b1;
  logic [NM-1:0] crc_mask  = '0;
  logic [NM-1:0] hook_mask = '0;
  bit          fr_pending = 1'b0;
  int          fr_dly     = 0;
  logic [7:0]  fr_motor   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (sweep_done) begin
      sd_prev = sd_last;
      sd_last = cyc;
      sd_count++;
    end
  end

  initial begin
    bus.frame_ack  = 1'b0;
    bus.frame_done = 1'b0;
    bus.frame_ok   = 1'b0;
    cfg_dirty_set  = '0;
    forever begin
      @(negedge clk);
      bus.frame_ack  = 1'b0;
      bus.frame_done = 1'b0;
      bus.frame_ok   = 1'b0;
      cfg_dirty_set  = '0;
      if (reset) begin
        fr_pending = 1'b0;
      end else if (fr_pending) begin
        if (fr_dly == 0) begin
          fr_pending = 1'b0;
          if (done_en) begin
            bus.frame_done = 1'b1;
            bus.frame_ok   = !crc_mask[fr_motor];
            cfg_dirty_set  = hook_mask & (NM'(1) << fr_motor);
          end
        end else begin
          fr_dly--;
        end
      end else if (bus.frame_req) begin
        bus.frame_ack = 1'b1;
        log_q.push_back({bus.frame_type, bus.frame_motor});
        fr_pending = 1'b1;
        fr_dly     = done_delay;
        fr_motor   = bus.frame_motor;
      end
    end
  end

  task automatic wait_sweep(input int max);
    int start = sd_count;
    int i = 0;
    while (sd_count == start && i < max) begin
      @(negedge clk);
      i++;
    end
    check("sweep_seen", 32'(sd_count != start), 32'd1);
  endtask

  task automatic wait_req(input int max, output int t_ack);
    t_ack = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.frame_req) begin
        t_ack = cyc + 1;
        break;
      end
    end
    check("req_seen", 32'(t_ack >= 0), 32'd1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, s;
    reset         = 1'b1;
    period_cycles = 32'd100;
    motor_enable  = 8'h05;
    clear_flags   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req",     32'(bus.frame_req),   32'd0);
    check("rst_type",    32'(bus.frame_type),  32'd0);
    check("rst_motor",   32'(bus.frame_motor), 32'd0);
    check("rst_timeout", 32'(timeout_flags),   32'd0);
    check("rst_crc",     32'(crc_flags),       32'd0);
    check("rst_overrun", 32'(overrun),         32'd0);
    check("rst_sweep",   32'(sweep_done),      32'd0);
    reset = 1'b0;

    // two sweeps over motors 0 and 2: config first, then setpoint
    wait_sweep(250);
    wait_sweep(250);
    check("sw_frames", 32'(log_q.size()), 32'd4);
    check("sw1_m0", 32'(log_q[0]), 32'h100);
    check("sw1_m2", 32'(log_q[1]), 32'h102);
    check("sw2_m0", 32'(log_q[2]), 32'h000);
    check("sw2_m2", 32'(log_q[3]), 32'h002);
    check("sw_period", 32'(sd_last - sd_prev), 32'd100);
    check("sw_flags", 32'({timeout_flags, crc_flags, 7'd0, overrun}), 32'd0);

    // CRC failure on motor 3 config frame keeps it dirty
    motor_enable = 8'h08;
    crc_mask     = 8'h08;
    log_q.delete();
    wait_sweep(150);
    check("crc_flag", 32'(crc_flags), 32'h08);
    check("crc_frames", 32'(log_q.size()), 32'(CRC_FRAMES));
    check("crc_f0", 32'(log_q[0]), 32'h103);
    crc_mask = '0;
    log_q.delete();
    wait_sweep(150);
    check("crc_retype", 32'(log_q[0]), 32'h103);
    log_q.delete();
    wait_sweep(150);
    check("crc_cleared", 32'(log_q[0]), 32'h003);

    // dirty set coincident with successful config done on motor 1
    motor_enable = 8'h02;
    hook_mask    = 8'h02;
    log_q.delete();
    wait_sweep(150);
    hook_mask = '0;
    check("dset_a", 32'(log_q[0]), 32'h101);
    log_q.delete();
    wait_sweep(150);
    check("dset_b", 32'(log_q[0]), 32'h101);
    log_q.delete();
    wait_sweep(150);
    check("dset_c", 32'(log_q[0]), 32'h001);

    // overrun with a short period and a slow framer, then halt and clear
    motor_enable  = 8'h01;
    period_cycles = 32'd10;
    done_delay    = 50;
    wait_sweep(300);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_crc_sticky", 32'(crc_flags), 32'h08);
    period_cycles = 32'd0;
    done_delay    = 0;
    repeat (20) @(negedge clk);
    s = sd_count;
    repeat (50) @(negedge clk);
    check("halted", 32'(sd_count), 32'(s));
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    @(negedge clk);
    check("ovr_clear", 32'(overrun), 32'd0);
    check("crc_clear", 32'(crc_flags), 32'd0);

    // done arriving in the same cycle the timeout expires counts as done
    done_delay    = TO - 1;
    period_cycles = 32'd10;
    wait_req(40, t0);
    period_cycles = 32'd0;
    wait_sweep(TO + 100);
    check("edge_no_timeout", 32'(timeout_flags), 32'd0);
    check("edge_no_crc", 32'(crc_flags), 32'd0);

    // framer never completes: timeout flag after TIMEOUT_CYCLES
    done_delay    = 0;
    done_en       = 1'b0;
    period_cycles = 32'd10;
    wait_req(40, t0);
    period_cycles = 32'd0;
    t1 = -1;
    for (int i = 0; i < 2 * TO + 100; i++) begin
      @(negedge clk);
      if (timeout_flags[0]) begin
        t1 = cyc;
        break;
      end
    end
    check("to_latency", 32'(t1 - t0), 32'(TO_LAT));
    check("to_flags", 32'(timeout_flags), 32'h01);
    wait_sweep(50);
    done_en = 1'b1;

    // reset in the middle of WAIT
    done_delay    = 100;
    period_cycles = 32'd10;
    wait_req(40, t0);
    repeat (25) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_req", 32'(bus.frame_req), 32'd0);
    check("mrst_flags", 32'({timeout_flags, crc_flags}), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    check("mrst_motor", 32'({bus.frame_type, bus.frame_motor}), 32'd0);
    done_delay   = 0;
    motor_enable = 8'h05;
    repeat (2) @(negedge clk);
    log_q.delete();
    reset = 1'b0;
    wait_sweep(100);
    check("mrst_frames", 32'(log_q.size()), 32'd2);
    check("mrst_f0", 32'(log_q[0]), 32'h100);
    check("mrst_f1", 32'(log_q[1]), 32'h102);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
